// File: rtl/qspi_seq_pkg.sv
// Shared types and helpers for the QSPI data-phase sequencer.
// Holds the sequencer state encoding and the byte/word sizing constants.
package qspi_seq_pkg;

   localparam int BytesPerWord = 4;
   localparam int ByteW        = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TX,
      ST_TX_FLUSH,
      ST_RX,
      ST_RX_PAD,
      ST_RX_DRAIN,
      ST_ABORT,
      ST_DONE
   } seq_state_e;

   // Number of 32-bit words needed to carry len bytes. The extra top bit keeps len+3 from overflowing.
   function automatic logic [31:0] ceil_words(input logic [31:0] len);
      logic [32:0] sum;
      logic [32:0] quot;
      sum  = {1'b0, len} + 33'd3;
      quot = sum >> 2;
      return quot[31:0];
   endfunction

endpackage

// File: rtl/qspi_byte_counter.sv
// Loadable down-counter used for remaining bytes, remaining words and pad bytes.
// Decrements only on a handshake and never wraps below zero.
module qspi_byte_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o,
   output logic         one_o
);

   logic [W-1:0] cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else if (load_i) begin
         cnt_q <= load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero_o = (cnt_q == '0);
   assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/qspi_data_seq.sv
// QSPI data-phase sequencer: steers host words through the TX unpacker and
// deserializer bytes through the RX packer, counting, flushing and padding.
module qspi_data_seq
   import qspi_seq_pkg::*;
#(
   parameter int LenW  = 16,
   parameter int WordW = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             dir_i,
   input  logic [LenW-1:0]  len_i,
   input  logic             abort_i,
   output logic             busy_o,
   output logic             done_o,
   input  logic             host_wvalid_i,
   input  logic [WordW-1:0] host_wdata_i,
   output logic             host_wready_o,
   output logic             host_rvalid_o,
   output logic [WordW-1:0] host_rdata_o,
   input  logic             host_rready_i,
   output logic             up_wvalid_o,
   output logic [WordW-1:0] up_wdata_o,
   input  logic             up_wready_i,
   output logic             up_clr_o,
   input  logic             up_rvalid_i,
   input  logic [ByteW-1:0] up_rdata_i,
   output logic             up_rready_o,
   output logic             ser_valid_o,
   output logic [ByteW-1:0] ser_data_o,
   input  logic             ser_ready_i,
   input  logic             deser_valid_i,
   input  logic [ByteW-1:0] deser_data_i,
   output logic             deser_ready_o,
   output logic             pk_wvalid_o,
   output logic [ByteW-1:0] pk_wdata_o,
   input  logic             pk_wready_i,
   output logic             pk_clr_o,
   input  logic             pk_rvalid_i,
   input  logic [WordW-1:0] pk_rdata_i,
   output logic             pk_rready_o
);

   seq_state_e state_q;
   logic [1:0] rem2_q;

   logic byte_zero, byte_one;
   logic word_zero, unused_word_one;
   logic pad_zero, pad_one;

   logic st_tx, st_rx, st_pad, st_rx_side;
   logic start_ok, tx_byte_hs, rx_byte_hs, pad_hs, host_r_hs, word_hs;
   logic pad_load;

   assign st_tx      = (state_q == ST_TX);
   assign st_rx      = (state_q == ST_RX);
   assign st_pad     = (state_q == ST_RX_PAD);
   assign st_rx_side = st_rx || st_pad || (state_q == ST_RX_DRAIN);

   // NOTE: outputs decode only registered state and the opposite side's handshake, so no latch and no valid->ready loop.
   assign busy_o   = (state_q != ST_IDLE);
   assign done_o   = (state_q == ST_DONE);
   assign up_clr_o = (state_q == ST_TX_FLUSH) || (state_q == ST_ABORT);
   assign pk_clr_o = (state_q == ST_ABORT);

   assign up_wvalid_o   = st_tx && host_wvalid_i && !word_zero;
   assign host_wready_o = st_tx && up_wready_i && !word_zero;
   assign up_wdata_o    = st_tx ? host_wdata_i : '0;

   assign ser_valid_o = st_tx && up_rvalid_i && !byte_zero;
   assign up_rready_o = st_tx && ser_ready_i && !byte_zero;
   assign ser_data_o  = st_tx ? up_rdata_i : '0;

   assign deser_ready_o = st_rx && pk_wready_i && !byte_zero;
   assign pk_wvalid_o   = (st_rx && deser_valid_i && !byte_zero) || (st_pad && !pad_zero);
   assign pk_wdata_o    = st_rx ? deser_data_i : '0;

   assign host_rvalid_o = st_rx_side && pk_rvalid_i;
   assign host_rdata_o  = st_rx_side ? pk_rdata_i : '0;
   assign pk_rready_o   = st_rx_side && host_rready_i;

   assign start_ok   = (state_q == ST_IDLE) && start_i;
   assign word_hs    = up_wvalid_o && up_wready_i;
   assign tx_byte_hs = ser_valid_o && ser_ready_i;
   assign rx_byte_hs = st_rx && pk_wvalid_o && pk_wready_i;
   assign pad_hs     = st_pad && pk_wvalid_o && pk_wready_i;
   assign host_r_hs  = host_rvalid_o && host_rready_i;
   assign pad_load   = rx_byte_hs && byte_one && (rem2_q != 2'd0);

   qspi_byte_counter #(.W(LenW)) u_byte_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (start_ok),
      .load_val_i (len_i),
      .dec_i      (tx_byte_hs || rx_byte_hs),
      .zero_o     (byte_zero),
      .one_o      (byte_one)
   );

   qspi_byte_counter #(.W(LenW)) u_word_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (start_ok),
      .load_val_i (LenW'(ceil_words(32'(len_i)))),
      .dec_i      (word_hs),
      .zero_o     (word_zero),
      .one_o      (unused_word_one)
   );

   qspi_byte_counter #(.W(3)) u_pad_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (pad_load),
      .load_val_i (3'(BytesPerWord) - {1'b0, rem2_q}),
      .dec_i      (pad_hs),
      .zero_o     (pad_zero),
      .one_o      (pad_one)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         rem2_q  <= 2'd0;
      end else if (abort_i && (state_q != ST_IDLE)) begin
         // Abort overrides every other transition, including the DONE exit.
         state_q <= ST_ABORT;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  rem2_q <= len_i[1:0];
                  if (len_i == '0)  state_q <= ST_DONE;
                  else if (dir_i)   state_q <= ST_RX;
                  else              state_q <= ST_TX;
               end
            end
            ST_TX: begin
               if (tx_byte_hs && byte_one) state_q <= ST_TX_FLUSH;
            end
            ST_TX_FLUSH: state_q <= ST_DONE;
            ST_RX: begin
               if (rx_byte_hs && byte_one) begin
                  state_q <= (rem2_q == 2'd0) ? ST_RX_DRAIN : ST_RX_PAD;
               end
            end
            ST_RX_PAD: begin
               if (pad_hs && pad_one) state_q <= ST_RX_DRAIN;
            end
            ST_RX_DRAIN: begin
               if (host_r_hs) state_q <= ST_DONE;
            end
            ST_ABORT: state_q <= ST_IDLE;
            ST_DONE:  state_q <= ST_IDLE;
            default:  state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qspi_data_seq.sv
// Self-checking bench for qspi_data_seq with behavioural unpacker/packer FIFOs
// and a byte-stream reference model derived from the transfer rules.
module tb_qspi_data_seq;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i, dir_i, abort_i;
   logic [15:0] len_i;
   logic        busy_o, done_o;
   logic        host_wvalid_i, host_wready_o;
   logic [31:0] host_wdata_i;
   logic        host_rvalid_o, host_rready_i;
   logic [31:0] host_rdata_o;
   logic        up_wvalid_o, up_wready_i, up_clr_o;
   logic [31:0] up_wdata_o;
   logic        up_rvalid_i, up_rready_o;
   logic [7:0]  up_rdata_i;
   logic        ser_valid_o, ser_ready_i;
   logic [7:0]  ser_data_o;
   logic        deser_valid_i, deser_ready_o;
   logic [7:0]  deser_data_i;
   logic        pk_wvalid_o, pk_wready_i, pk_clr_o;
   logic [7:0]  pk_wdata_o;
   logic        pk_rvalid_i, pk_rready_o;
   logic [31:0] pk_rdata_i;

   always #5 clk_i = ~clk_i;

   qspi_data_seq #(.LenW(16), .WordW(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .dir_i(dir_i), .len_i(len_i),
      .abort_i(abort_i), .busy_o(busy_o), .done_o(done_o),
      .host_wvalid_i(host_wvalid_i), .host_wdata_i(host_wdata_i), .host_wready_o(host_wready_o),
      .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_rready_i(host_rready_i),
      .up_wvalid_o(up_wvalid_o), .up_wdata_o(up_wdata_o), .up_wready_i(up_wready_i), .up_clr_o(up_clr_o),
      .up_rvalid_i(up_rvalid_i), .up_rdata_i(up_rdata_i), .up_rready_o(up_rready_o),
      .ser_valid_o(ser_valid_o), .ser_data_o(ser_data_o), .ser_ready_i(ser_ready_i),
      .deser_valid_i(deser_valid_i), .deser_data_i(deser_data_i), .deser_ready_o(deser_ready_o),
      .pk_wvalid_o(pk_wvalid_o), .pk_wdata_o(pk_wdata_o), .pk_wready_i(pk_wready_i), .pk_clr_o(pk_clr_o),
      .pk_rvalid_i(pk_rvalid_i), .pk_rdata_i(pk_rdata_i), .pk_rready_o(pk_rready_o)
   );

   // FIFO models and recorders
   logic        u_full, p_full;
   logic [31:0] u_word, p_word;
   int          u_idx, p_lane;
   logic [31:0] src_words[$];
   logic [7:0]  src_bytes[$];
   logic [7:0]  got_ser[$];
   logic [31:0] got_host[$];
   int          hidx, didx, n_up_clr, n_pk_clr, n_done, n_pk_w;
   int          cyc, clr_cyc, done_cyc, last_host_cyc;
   int unsigned pct;
   bit          rready_hold;
   int          tests, fails;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic drive_env();
      up_wready_i   = !u_full;
      up_rvalid_i   = u_full;
      up_rdata_i    = u_word[8*u_idx +: 8];
      pk_wready_i   = !p_full;
      pk_rvalid_i   = p_full;
      pk_rdata_i    = p_word;
      host_wvalid_i = (hidx < src_words.size()) && ($urandom_range(99) < pct);
      host_wdata_i  = (hidx < src_words.size()) ? src_words[hidx] : 32'hDEAD_BEEF;
      deser_valid_i = (didx < src_bytes.size()) && ($urandom_range(99) < pct);
      deser_data_i  = (didx < src_bytes.size()) ? src_bytes[didx] : 8'hA5;
      ser_ready_i   = ($urandom_range(99) < pct);
      host_rready_i = !rready_hold && ($urandom_range(99) < pct);
   endtask

   // One clock: sample handshakes at the falling edge, update models after the rising edge.
   task automatic tick();
      logic hw, uw, urd, dh, pw, pr_pk, pr, uc, pc;
      logic [31:0] uwd;
      logic [7:0]  pd;
      @(negedge clk_i);
      hw    = host_wvalid_i && host_wready_o;
      uw    = up_wvalid_o && up_wready_i;
      uwd   = up_wdata_o;
      urd   = up_rvalid_i && up_rready_o;
      dh    = deser_valid_i && deser_ready_o;
      pw    = pk_wvalid_o && pk_wready_i;
      pd    = pk_wdata_o;
      pr_pk = pk_rvalid_i && pk_rready_o;
      pr    = host_rvalid_o && host_rready_i;
      uc    = up_clr_o;
      pc    = pk_clr_o;
      if (ser_valid_o && ser_ready_i) got_ser.push_back(ser_data_o);
      if (pr) begin got_host.push_back(host_rdata_o); last_host_cyc = cyc; end
      if (uc) begin n_up_clr++; clr_cyc = cyc; end
      if (pc) n_pk_clr++;
      if (done_o) begin n_done++; done_cyc = cyc; end
      if (pw) n_pk_w++;
      @(posedge clk_i);
      #1;
      cyc++;
      if (hw) hidx++;
      if (dh) didx++;
      if (uc) begin
         u_full = 1'b0; u_idx = 0;
      end else if (uw) begin
         u_full = 1'b1; u_word = uwd; u_idx = 0;
      end else if (urd) begin
         if (u_idx == 3) begin u_full = 1'b0; u_idx = 0; end
         else u_idx++;
      end
      if (pc) begin
         p_full = 1'b0; p_word = '0; p_lane = 0;
      end else begin
         if (pr_pk) begin p_full = 1'b0; p_word = '0; p_lane = 0; end
         if (pw) begin
            p_word[8*p_lane +: 8] = pd;
            if (p_lane == 3) begin p_full = 1'b1; p_lane = 0; end
            else p_lane++;
         end
      end
      drive_env();
   endtask

   task automatic clear_rec();
      got_ser.delete(); got_host.delete();
      hidx = 0; didx = 0; n_up_clr = 0; n_pk_clr = 0; n_done = 0; n_pk_w = 0;
      clr_cyc = -1; done_cyc = -1; last_host_cyc = -1;
   endtask

   // Reference RX word: bytes packed LSB-first, zero beyond the programmed length.
   function automatic logic [31:0] rx_word(input int w, input int len);
      logic [31:0] e;
      e = '0;
      for (int k = 0; k < 4; k++) begin
         if (4*w + k < len) e = e | (32'(src_bytes[4*w + k]) << (8*k));
      end
      return e;
   endfunction

   task automatic run_xfer(input bit dir, input int len, input int hold);
      int nw, k;
      nw = (len + 3) / 4;
      clear_rec();
      rready_hold = (hold > 0);
      dir_i = dir; len_i = 16'(len); start_i = 1'b1;
      drive_env();
      tick();
      start_i = 1'b0;
      if (hold > 0) begin
         k = 0;
         while (!(host_rvalid_o && didx == len) && k < 1000) begin tick(); k++; end
         for (int h = 0; h < hold; h++) begin
            check_bit("drain_hold_valid", host_rvalid_o, 1'b1);
            check("drain_hold_data", host_rdata_o, rx_word(0, len));
            tick();
         end
         rready_hold = 1'b0;
         drive_env();
      end
      k = 0;
      while (n_done == 0 && k < 2000) begin tick(); k++; end
      check_bit("done_seen_in_budget", n_done > 0, 1'b1);
      tick();
      check("done_pulses", n_done, 1);
      check_bit("idle_after_done", busy_o, 1'b0);
      if (!dir) begin
         check("ser_count", got_ser.size(), len);
         for (int i = 0; i < got_ser.size() && i < len; i++)
            check("ser_byte", 32'(got_ser[i]), 32'(8'(src_words[i/4] >> (8*(i%4)))));
         check("host_words_taken", hidx, nw);
         check("up_clr_pulses", n_up_clr, 1);
         check("pk_clr_pulses", n_pk_clr, 0);
         check("done_after_flush", done_cyc, clr_cyc + 1);
      end else begin
         check("host_word_count", got_host.size(), nw);
         for (int w = 0; w < got_host.size() && w < nw; w++)
            check("host_word", got_host[w], rx_word(w, len));
         check("deser_taken", didx, len);
         check("pk_writes", n_pk_w, 4*nw);
         check("clr_pulses", n_up_clr + n_pk_clr, 0);
         check("done_after_host", done_cyc, last_host_cyc + 1);
      end
   endtask

   task automatic fill_tx(input int len);
      src_words.delete();
      for (int i = 0; i < (len + 3) / 4 + 1; i++) src_words.push_back($urandom);
   endtask

   task automatic fill_rx(input int len);
      src_bytes.delete();
      for (int i = 0; i < len + 2; i++) src_bytes.push_back(8'($urandom));
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0; pct = 100; rready_hold = 1'b0;
      u_full = 1'b0; u_word = '0; u_idx = 0;
      p_full = 1'b0; p_word = '0; p_lane = 0;
      start_i = 1'b0; dir_i = 1'b0; abort_i = 1'b0; len_i = '0;
      clear_rec();
      src_words.delete(); src_bytes.delete();
      rst_i = 1'b1;
      drive_env();
      #2;
      check_bit("rst_busy", busy_o, 1'b0);
      check_bit("rst_done", done_o, 1'b0);
      check("rst_outputs", 32'({host_wready_o, host_rvalid_o, up_wvalid_o, up_clr_o, up_rready_o,
                                ser_valid_o, deser_ready_o, pk_wvalid_o, pk_clr_o, pk_rready_o}), 32'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      drive_env();

      // TX len=8
      src_words.delete();
      src_words.push_back(32'h4433_2211); src_words.push_back(32'h8877_6655); src_words.push_back(32'h1234_5678);
      pct = 70;
      run_xfer(1'b0, 8, 0);

      // TX len=5: only five bytes go out, the rest of the last word is flushed
      src_words.delete();
      src_words.push_back(32'hDDCC_BBAA); src_words.push_back(32'h0000_00EE); src_words.push_back(32'hCAFE_F00D);
      run_xfer(1'b0, 5, 0);

      // RX len=6: final word zero-padded
      src_bytes.delete();
      for (int i = 1; i <= 8; i++) src_bytes.push_back(8'(i));
      run_xfer(1'b1, 6, 0);
      check("rx6_word1", got_host.size() > 1 ? got_host[1] : 32'hFFFF_FFFF, 32'h0000_0605);

      // RX len=4 with host stalled in drain
      src_bytes.delete();
      for (int i = 1; i <= 6; i++) src_bytes.push_back(8'(i));
      run_xfer(1'b1, 4, 10);

      // Zero-length transfer
      clear_rec();
      src_words.delete(); src_words.push_back(32'h1234_5678);
      dir_i = 1'b0; len_i = '0; start_i = 1'b1;
      drive_env();
      tick();
      start_i = 1'b0;
      check_bit("len0_done_high", done_o, 1'b1);
      check_bit("len0_up_wvalid", up_wvalid_o, 1'b0);
      tick();
      check_bit("len0_done_low", done_o, 1'b0);
      check_bit("len0_idle", busy_o, 1'b0);
      check("len0_no_traffic", hidx + got_ser.size() + n_pk_w, 0);

      // Abort mid-TX after three bytes
      fill_tx(8);
      clear_rec();
      pct = 100;
      dir_i = 1'b0; len_i = 16'd8; start_i = 1'b1;
      drive_env();
      tick();
      start_i = 1'b0;
      for (int k = 0; k < 50 && got_ser.size() < 3; k++) tick();
      check("abort_bytes_before", got_ser.size(), 3);
      pct = 0;
      drive_env();
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      check_bit("abort_up_clr", up_clr_o, 1'b1);
      check_bit("abort_pk_clr", pk_clr_o, 1'b1);
      tick();
      check_bit("abort_up_clr_drop", up_clr_o, 1'b0);
      check_bit("abort_idle", busy_o, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      check("abort_clr_pulses", n_up_clr + n_pk_clr, 2);
      check("abort_no_done", n_done, 0);
      pct = 80;
      fill_tx(7);
      run_xfer(1'b0, 7, 0);

      // Randomized transfers
      for (int t = 0; t < 14; t++) begin
         int len;
         bit d;
         len = int'($urandom_range(23, 1));
         d   = 1'($urandom_range(1));
         pct = $urandom_range(100, 40);
         if (d) fill_rx(len); else fill_tx(len);
         run_xfer(d, len, 0);
      end

      // Reset asserted mid-RX
      pct = 100;
      fill_rx(12);
      clear_rec();
      dir_i = 1'b1; len_i = 16'd12; start_i = 1'b1;
      drive_env();
      tick();
      start_i = 1'b0;
      tick(); tick();
      #2;
      rst_i = 1'b1;
      #1;
      check_bit("midrst_busy", busy_o, 1'b0);
      check("midrst_outputs", 32'({host_rvalid_o, deser_ready_o, pk_wvalid_o, pk_rready_o,
                                   up_clr_o, pk_clr_o, done_o}), 32'd0);
      u_full = 1'b0; u_idx = 0; p_full = 1'b0; p_word = '0; p_lane = 0;
      n_up_clr = 0; n_pk_clr = 0; n_done = 0;
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); #1;
      drive_env();
      check_bit("midrst_idle_after", busy_o, 1'b0);
      tick(); tick();
      check("midrst_no_clr", n_up_clr + n_pk_clr + n_done, 0);
      fill_rx(9);
      run_xfer(1'b1, 9, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
